fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Consumer end of the next-PC selection path; owns the PC register.
- Accepts a redirect target when a branch/jal/jalr resolves, otherwise advances PC by 4.
- Issues instruction-memory requests over a valid/ready handshake and buffers returned {pc, instr} pairs in a small FIFO.
- Presents the FIFO head to decode with a valid/ready handshake; flushes stale fetches on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BUF_DEPTH, 2, fetch FIFO entries (power of 2, >=2).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset rst, synchronous, active-high
- redirect_valid  input  1  taken branch/jump this cycle
- redirect_target  input  32  new PC; bits [1:0] ignored and forced to 0
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  fetch address (word aligned)
- imem_rsp_valid  input  1  response valid, one cycle, one per accepted request
- imem_rsp_data  input  32  instruction word
- out_valid  output  1  FIFO head valid
- out_ready  input  1  decode consumes head
- out_pc  output  32  PC of head instruction
- out_instr  output  32  head instruction

Behaviour:
- Reset (sync, clk edge with rst=1): pc=RESET_PC, state=REQ, FIFO empty, out_valid=0, imem_req_valid=0 during the reset cycle.
  - out_pc and out_instr read 0 while the FIFO is empty.
  - rst mid-operation abandons any outstanding response; a response arriving after reset is ignored because state=REQ.
- State machine: REQ, WAIT, DROP. At most one request outstanding.
- REQ state:
  - imem_req_valid = (fifo_count < BUF_DEPTH); imem_req_addr = pc.
  - On handshake: req_pc <= pc, pc <= pc + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), go WAIT.
  - Without handshake, valid stays asserted and the address stays stable, except on redirect.
- WAIT state:
  - imem_req_valid=0.
  - On imem_rsp_valid: push {req_pc, imem_rsp_data}, go REQ.
  - The push becomes visible on out_valid the next cycle.
- DROP state:
  - imem_req_valid=0.
  - On imem_rsp_valid: discard the response, go REQ.
- Redirect:
  - Highest priority: pc <= {redirect_target[31:2], 2'b00}; FIFO flushed (count=0, out_valid=0 next cycle).
  - In REQ with no handshake: go to / stay in REQ; the new address is presented next cycle.
  - In REQ with a handshake in the same cycle: the accepted request is stale, go DROP, and pc is not incremented.
  - In WAIT without a response: go DROP.
  - In WAIT with a response in the same cycle: discard the response, go REQ.
  - In DROP: stay DROP, or go REQ if the response arrives that cycle.
- FIFO:
  - Simultaneous push and pop: allowed, count unchanged.
  - Pop only when out_valid & out_ready.
  - Flush beats both push and pop.
  - Full: no new request is issued, so no overflow is possible.
- Latency (zero-wait memory, rsp one cycle after request):
  - Request at cycle N, response at N+1, out_valid at N+2.
  - Sustained throughput is 1 instruction per 2 cycles.
- First request is presented on the first cycle after rst deasserts.

Decomposition:
- Shared package (rv_pkg): XLEN=32, INSTR_NOP=32'h0000_0013, default RESET_PC, PC_STEP=4.
- The state encoding enum for REQ/WAIT/DROP is local to the module.
- One sub-module: fetch_fifo.
  - Synchronous FIFO, BUF_DEPTH x 64 bits ({pc, instr}).
  - Ports: push, pop, flush, full, empty, count.

Test Plan:
- Reset release, ready=1, rsp one cycle later with instr 0x00000013, out_ready=1:
  - Addresses 0x0, 0x4, 0x8 issued every 2 cycles.
  - out_pc sequence 0x0, 0x4, 0x8; first out_valid 2 cycles after the first request.
- out_ready=0 backpressure:
  - FIFO fills 2 entries (pc 0x0, 0x4), then imem_req_valid stays 0.
  - Raising out_ready resumes fetching at 0x8.
- Redirect to 0x100 while in WAIT for pc 0x8:
  - The response for 0x8 is discarded and the FIFO is flushed.
  - Next request address 0x100; next out_pc 0x100.
- Redirect to 0x203 in the same cycle as a request handshake at 0xC:
  - State goes DROP and the 0xC response is dropped.
  - Next request address 0x200.
- Hold imem_req_ready=0 for 5 cycles:
  - imem_req_valid stays 1 with imem_req_addr stable.
  - Redirect mid-hold changes the address to the target on the next cycle.
- pc=0xFFFFFFFC fetched: next request address 0x00000000. Then assert rst for one cycle while in WAIT:
  - pc returns to RESET_PC and the FIFO empties.
  - The late response is ignored.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared constants for the RV32 front end: datapath width, NOP encoding,
// the default reset vector and the sequential PC increment.
package rv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
endpackage

// File: rtl/fetch_unit_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} pairs; flush empties it in one
// cycle and takes priority over a simultaneous push or pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem[rd_ptr_q];

  // A push into a full FIFO is only accepted if the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one outstanding imem request at a
// time, buffers responses for decode and discards fetches made stale by redirects.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);
  typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;

  state_t         state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic           req_fire;
  logic           fifo_push, fifo_pop, fifo_flush;
  logic           fifo_full, fifo_empty;
  logic [63:0]    fifo_rdata;
  logic [$clog2(BUF_DEPTH):0] fifo_count;

  assign imem_req_valid = (state_q == REQ) && !fifo_full && !rst;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign out_valid = !fifo_empty;
  assign out_pc    = fifo_empty ? '0 : fifo_rdata[63:32];
  assign out_instr = fifo_empty ? '0 : fifo_rdata[31:0];
  assign fifo_pop  = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      REQ: begin
        if (req_fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_STEP;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          fifo_push = 1'b1;
          state_d   = REQ;
        end
      end
      DROP: begin
        if (imem_rsp_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
    // Redirect overrides everything: any request in flight now belongs to the
    // wrong path, so its response must be swallowed in DROP.
    if (redirect_valid) begin
      pc_d       = {redirect_target[31:2], 2'b00};
      fifo_flush = 1'b1;
      fifo_push  = 1'b0;
      case (state_q)
        REQ:     state_d = req_fire ? DROP : REQ;
        WAIT:    state_d = imem_rsp_valid ? REQ : DROP;
        DROP:    state_d = imem_rsp_valid ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    req_pc_q <= req_pc_d;
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .W     (64)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata ({req_pc_q, imem_rsp_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a zero-wait memory model returns addr+0x13
// one cycle after each accepted request; each task checks one scenario.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int checks = 0;
  int failures = 0;
  logic mem_auto = 1'b1;

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr)
  );

  always #5 clk = ~clk;

  // Memory: sample the handshake mid-cycle, answer during the following cycle.
  initial begin
    logic        hs;
    logic [31:0] hs_addr;
    forever begin
      @(negedge clk);
      hs      = imem_req_valid && imem_req_ready;
      hs_addr = imem_req_addr;
      @(posedge clk);
      #1;
      if (mem_auto) begin
        imem_rsp_valid = hs;
        imem_rsp_data  = hs ? hs_addr + 32'h13 : 32'h0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy, input logic ordy);
    rst = 1'b1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    imem_req_ready = rdy;
    out_ready = ordy;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
    tick();
    rst = 1'b0;
    imem_req_ready = 1'b0;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL first_req_valid got=%b exp=1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin failures++; $display("FAIL first_req_addr got=%h exp=0", imem_req_addr); end
    tick();
  endtask

  task automatic test_sequential();
    logic [6:0]  e_rv   = 7'b1010101;
    logic [6:0]  e_ov   = 7'b1010100;
    logic [31:0] e_addr [7] = '{32'h0, 32'h0, 32'h4, 32'h0, 32'h8, 32'h0, 32'hC};
    logic [31:0] e_pc   [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8};
    do_reset(1'b1, 1'b1);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      checks++; if (imem_req_valid !== e_rv[k]) begin failures++; $display("FAIL seq_req_valid c%0d got=%b exp=%b", k, imem_req_valid, e_rv[k]); end
      if (e_rv[k]) begin
        checks++; if (imem_req_addr !== e_addr[k]) begin failures++; $display("FAIL seq_req_addr c%0d got=%h exp=%h", k, imem_req_addr, e_addr[k]); end
      end
      checks++; if (out_valid !== e_ov[k]) begin failures++; $display("FAIL seq_out_valid c%0d got=%b exp=%b", k, out_valid, e_ov[k]); end
      if (e_ov[k]) begin
        checks++; if (out_pc !== e_pc[k]) begin failures++; $display("FAIL seq_out_pc c%0d got=%h exp=%h", k, out_pc, e_pc[k]); end
        checks++; if (out_instr !== e_pc[k] + 32'h13) begin failures++; $display("FAIL seq_out_instr c%0d got=%h exp=%h", k, out_instr, e_pc[k] + 32'h13); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    for (int k = 4; k < 7; k++) begin
      @(negedge clk);
      checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_full_req_valid c%0d got=%b exp=0", k, imem_req_valid); end
      checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL bp_full_out_pc c%0d got=%h exp=0", k, out_pc); end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_c7_req_valid got=%b exp=0", imem_req_valid); end
    tick();
    @(negedge clk);
    checks++; if (out_pc !== 32'h4) begin failures++; $display("FAIL bp_c8_out_pc got=%h exp=4", out_pc); end
    checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL bp_c8_req_valid got=%b exp=1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h8) begin failures++; $display("FAIL bp_c8_req_addr got=%h exp=8", imem_req_addr); end
    tick();
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8) begin failures++; $display("FAIL bp_c10_out got=%b/%h exp=1/00000008", out_valid, out_pc); end
    tick();
  endtask

  task automatic test_redirect_wait();
    do_reset(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rw_full_req_valid got=%b exp=0", imem_req_valid); end
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin failures++; $display("FAIL rw_req8 got=%b/%h exp=1/00000008", imem_req_valid, imem_req_addr); end
    tick();
    redirect_valid = 1'b1;
    redirect_target = 32'h100;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin failures++; $display("FAIL rw_pre_out got=%b/%h exp=1/00000004", out_valid, out_pc); end
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rw_flush_out_valid got=%b exp=0", out_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin failures++; $display("FAIL rw_new_req got=%b/%h exp=1/00000100", imem_req_valid, imem_req_addr); end
    tick();
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin failures++; $display("FAIL rw_out_pc got=%b/%h exp=1/00000100", out_valid, out_pc); end
    checks++; if (out_instr !== 32'h113) begin failures++; $display("FAIL rw_out_instr got=%h exp=00000113", out_instr); end
    checks++; if (imem_req_addr !== 32'h104) begin failures++; $display("FAIL rw_next_addr got=%h exp=00000104", imem_req_addr); end
    tick();
  endtask

  task automatic test_redirect_handshake();
    do_reset(1'b1, 1'b1);
    for (int k = 0; k < 6; k++) tick();
    redirect_valid = 1'b1;
    redirect_target = 32'h203;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hC) begin failures++; $display("FAIL rh_req_c got=%b/%h exp=1/0000000c", imem_req_valid, imem_req_addr); end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rh_drop_req_valid got=%b exp=0", imem_req_valid); end
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rh_dropped_out_valid got=%b exp=0", out_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin failures++; $display("FAIL rh_new_req got=%b/%h exp=1/00000200", imem_req_valid, imem_req_addr); end
    tick();
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_instr !== 32'h213) begin failures++; $display("FAIL rh_out got=%b/%h/%h exp=1/00000200/00000213", out_valid, out_pc, out_instr); end
    tick();
  endtask

  task automatic test_stall();
    do_reset(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin redirect_valid = 1'b1; redirect_target = 32'h40; end
      @(negedge clk);
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL st_hold c%0d got=%b/%h exp=1/00000000", k, imem_req_valid, imem_req_addr); end
      tick();
    end
    redirect_valid = 1'b0;
    for (int k = 3; k < 5; k++) begin
      @(negedge clk);
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin failures++; $display("FAIL st_redir c%0d got=%b/%h exp=1/00000040", k, imem_req_valid, imem_req_addr); end
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL st_wait_req_valid got=%b exp=0", imem_req_valid); end
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 32'h53) begin failures++; $display("FAIL st_out got=%b/%h/%h exp=1/00000040/00000053", out_valid, out_pc, out_instr); end
    tick();
  endtask

  task automatic test_wrap_reset();
    do_reset(1'b0, 1'b0);
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wr_req_top got=%b/%h exp=1/fffffffc", imem_req_valid, imem_req_addr); end
    tick();
    tick();
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL wr_wrap_addr got=%b/%h exp=1/00000000", imem_req_valid, imem_req_addr); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_instr !== 32'h0000_000F) begin failures++; $display("FAIL wr_out got=%b/%h/%h exp=1/fffffffc/0000000f", out_valid, out_pc, out_instr); end
    mem_auto = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL wr_rst_req_valid got=%b exp=0", imem_req_valid); end
    tick();
    rst = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin failures++; $display("FAIL wr_rst_fifo got=%b/%h exp=0/00000000", out_valid, out_pc); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL wr_rst_pc got=%b/%h exp=1/00000000", imem_req_valid, imem_req_addr); end
    tick();
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL wr_late_rsp got=%b exp=0", out_valid); end
    mem_auto = 1'b1;
    tick();
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_handshake();
    test_stall();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
